// File: rtl/ahb_dma_pkg.sv
// Purpose : shared types and constants for the AHB DMA channel arbiter.
// Latency : n/a (package only).
// Backpres: n/a.
package ahb_dma_pkg;

  // Width of one per-channel priority field as carried on pri_ch/pri_out/gnt_pri.
  localparam int PRI_W = 3;

  // Arbiter grant FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ahb_dma_rr_pick.sv
// Purpose : round-robin find-first over an eligibility mask, starting just after i_last.
// Latency : combinational.
// Backpres: none; pure function of inputs.
//
// Ports:
//   i_mask  [N-1:0]  eligible channels
//   i_last  [W-1:0]  previously served channel (searched last)
//   o_idx   [W-1:0]  first eligible index after i_last, wrapping
//   o_found          at least one bit of i_mask set
module ahb_dma_rr_pick #(
  parameter int N = 12,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  logic         w_hi_found;
  logic [W-1:0] w_hi_idx;
  logic         w_lo_found;
  logic [W-1:0] w_lo_idx;

  // Two scans instead of an explicit rotate: the "hi" scan finds the first
  // eligible index strictly above i_last; if there is none, the search wraps
  // and the plain lowest eligible index wins (which may be i_last itself).
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (i_mask[j] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = W'(j);
      end
      if (i_mask[j] && (j > int'(i_last)) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_idx   = W'(j);
      end
    end
  end

  assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_found = w_lo_found;

endmodule

// File: rtl/ahb_dma_ch_arb.sv
// Purpose : DMA channel arbiter; highest effective priority wins, round-robin among ties,
//           with a grant/ack/done handshake toward the transfer engine.
// Latency : grant visible 1 cycle after a request is sampled in IDLE; pri_out 1 cycle.
// Backpres: a grant is held until gnt_ack or withdrawal; no new grant until ch_done
//           plus one dead cycle; no preemption.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   valid   [CH_NUM-1:0]  per-channel request
//   pri_ch  [3*CH_NUM-1:0] per-channel priority, channel k at [3k+2:3k]
//   gnt_ack, ch_done      engine accepts grant / finished transfer
//   pri_out               registered max effective priority of valid channels
//   gnt_valid, gnt_ch, gnt_pri  grant offer
//   busy                  granted transfer in progress
module ahb_dma_ch_arb
  import ahb_dma_pkg::*;
#(
  parameter int CH_NUM     = 12,
  parameter int PRI_LEVELS = 8,
  parameter int CH_W       = $clog2(CH_NUM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_NUM-1:0]       valid,
  input  logic [PRI_W*CH_NUM-1:0] pri_ch,
  input  logic                    gnt_ack,
  input  logic                    ch_done,
  output logic [PRI_W-1:0]        pri_out,
  output logic                    gnt_valid,
  output logic [CH_W-1:0]         gnt_ch,
  output logic [PRI_W-1:0]        gnt_pri,
  output logic                    busy
);

  // PRI_LEVELS is a power of two, so masking with LEVELS-1 keeps exactly
  // log2(PRI_LEVELS) low bits.
  localparam logic [PRI_W-1:0] LVL_MASK = PRI_W'(PRI_LEVELS - 1);

  logic [PRI_W-1:0] w_eff [CH_NUM];
  logic [PRI_W-1:0] w_max;
  logic [CH_NUM-1:0] w_elig;
  logic [CH_W-1:0]  w_win;
  logic             w_found;

  arb_state_t       r_state;
  logic [PRI_W-1:0] r_pri_out;
  logic             r_gnt_valid;
  logic [CH_W-1:0]  r_gnt_ch;
  logic [PRI_W-1:0] r_gnt_pri;
  logic             r_busy;
  logic [CH_W-1:0]  r_last_ch;

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      w_eff[k] = pri_ch[k*PRI_W +: PRI_W] & LVL_MASK;
    end
  end

  // Maximum effective priority over requesting channels; 0 when none request.
  always_comb begin
    w_max = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (valid[k] && (w_eff[k] > w_max)) begin
        w_max = w_eff[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      w_elig[k] = valid[k] && (w_eff[k] == w_max);
    end
  end

  ahb_dma_rr_pick #(
    .N (CH_NUM),
    .W (CH_W)
  ) u_rr_pick (
    .i_mask  (w_elig),
    .i_last  (r_last_ch),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // pri_out tracks the request set every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pri_out <= '0;
    end else begin
      r_pri_out <= w_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt_valid <= 1'b0;
      r_gnt_ch    <= '0;
      r_gnt_pri   <= '0;
      r_busy      <= 1'b0;
      r_last_ch   <= CH_W'(CH_NUM - 1);
    end else begin
      case (r_state)
        IDLE: begin
          // w_found is set exactly when any channel requests.
          if (w_found) begin
            r_gnt_ch    <= w_win;
            r_gnt_pri   <= w_max;
            r_gnt_valid <= 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          // Ack wins over a same-cycle withdrawal; only an accepted grant
          // advances the round-robin pointer.
          if (gnt_ack) begin
            r_last_ch   <= r_gnt_ch;
            r_gnt_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= BUSY;
          end else if (!valid[r_gnt_ch]) begin
            r_gnt_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        BUSY: begin
          if (ch_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign pri_out   = r_pri_out;
  assign gnt_valid = r_gnt_valid;
  assign gnt_ch    = r_gnt_ch;
  assign gnt_pri   = r_gnt_pri;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ahb_dma_ch_arb.sv
// Purpose : self-checking bench for ahb_dma_ch_arb (12 channels, 8 and 2 priority levels).
// Latency : n/a.
// Backpres: n/a.
module tb_ahb_dma_ch_arb;

  logic        clk;
  logic        rst_n;
  logic [11:0] valid;
  logic [35:0] pri_ch;
  logic        gnt_ack;
  logic        ch_done;

  logic [2:0]  po_a, gp_a, po_b, gp_b;
  logic        gv_a, busy_a, gv_b, busy_b;
  logic [3:0]  ch_a, ch_b;

  int checks = 0;
  int errors = 0;

  ahb_dma_ch_arb #(.CH_NUM(12), .PRI_LEVELS(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pri_ch(pri_ch),
    .gnt_ack(gnt_ack), .ch_done(ch_done),
    .pri_out(po_a), .gnt_valid(gv_a), .gnt_ch(ch_a), .gnt_pri(gp_a), .busy(busy_a)
  );

  ahb_dma_ch_arb #(.CH_NUM(12), .PRI_LEVELS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pri_ch(pri_ch),
    .gnt_ack(gnt_ack), .ch_done(ch_done),
    .pri_out(po_b), .gnt_valid(gv_b), .gnt_ch(ch_b), .gnt_pri(gp_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] pv(input int c0, input int p0, input int c1 = -1,
                                     input int p1 = 0, input int c2 = -1, input int p2 = 0);
    logic [35:0] r;
    logic [31:0] t;
    r = '0;
    t = p0; if (c0 >= 0) r[c0*3 +: 3] = t[2:0];
    t = p1; if (c1 >= 0) r[c1*3 +: 3] = t[2:0];
    t = p2; if (c2 >= 0) r[c2*3 +: 3] = t[2:0];
    return r;
  endfunction

  // ---------------- reference model (arithmetic over the priority rules) -------------
  int lv [2] = '{8, 2};
  int m_gv [2], m_busy [2], m_last [2], m_ch [2], m_pri [2], m_po [2];

  function automatic int eff(input logic [35:0] p, input int c, input int levels);
    return int'(p[c*3 +: 3]) % levels;
  endfunction

  function automatic int m_max(input logic [11:0] v, input logic [35:0] p, input int levels);
    int mx = 0;
    for (int c = 0; c < 12; c++)
      if (v[c] && eff(p, c, levels) > mx) mx = eff(p, c, levels);
    return mx;
  endfunction

  function automatic int m_win(input logic [11:0] v, input logic [35:0] p, input int levels,
                               input int last);
    int mx = m_max(v, p, levels);
    for (int i = 1; i <= 12; i++) begin
      int c = (last + i) % 12;
      if (v[c] && eff(p, c, levels) == mx) return c;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_gv[k] = 0; m_busy[k] = 0; m_last[k] = 11; m_ch[k] = 0; m_pri[k] = 0; m_po[k] = 0;
    end
  endtask

  // Advance both models across one clock edge using the currently driven inputs.
  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      int npo = m_max(valid, pri_ch, lv[k]);
      if (m_gv[k] != 0) begin
        if (gnt_ack) begin
          m_last[k] = m_ch[k]; m_gv[k] = 0; m_busy[k] = 1;
        end else if (!valid[m_ch[k]]) begin
          m_gv[k] = 0;
        end
      end else if (m_busy[k] != 0) begin
        if (ch_done) m_busy[k] = 0;
      end else if (valid != 12'd0) begin
        m_ch[k]  = m_win(valid, pri_ch, lv[k], m_last[k]);
        m_pri[k] = m_max(valid, pri_ch, lv[k]);
        m_gv[k]  = 1;
      end
      m_po[k] = npo;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [11:0] v;
    logic [35:0] p;
    logic        ack;
    logic        done;
    logic        egv;
    logic [3:0]  ech;
    logic [2:0]  epri;
    logic [2:0]  epo;
    logic        ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [11:0] v, input logic [35:0] p,
                              input logic ack, input logic done, input logic egv,
                              input int ech, input int epri, input int epo, input logic ebusy);
    vec_t r;
    r.rst = rst; r.v = v; r.p = p; r.ack = ack; r.done = done; r.egv = egv;
    r.ech = 4'(ech); r.epri = 3'(epri); r.epo = 3'(epo); r.ebusy = ebusy;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = '0; pri_ch = '0; gnt_ack = 1'b0; ch_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [35:0] pa, pb;
    rst_n = 1'b0; valid = '0; pri_ch = '0; gnt_ack = 1'b0; ch_done = 1'b0;
    pa = pv(3, 2, 7, 5);
    pb = pv(1, 6, 4, 6, 9, 6);

    //             rst  valid    pri  ack  done gv  ch pri po busy
    tbl.push_back(mk(1, 12'hFFF, '0,  0,   0,   0,  0, 0,  0, 0)); // reset, all requesting
    tbl.push_back(mk(0, 12'hFFF, '0,  0,   0,   1,  0, 0,  0, 0)); // first grant ch0
    tbl.push_back(mk(0, 12'hFFF, '0,  1,   0,   0,  0, 0,  0, 1));
    tbl.push_back(mk(0, 12'h000, '0,  0,   1,   0,  0, 0,  0, 0));
    tbl.push_back(mk(0, 12'h088, pa,  0,   0,   1,  7, 5,  5, 0)); // ch3 p2 vs ch7 p5
    tbl.push_back(mk(0, 12'h088, pa,  1,   0,   0,  7, 5,  5, 1));
    tbl.push_back(mk(0, 12'h008, pa,  0,   1,   0,  0, 0,  2, 0));
    tbl.push_back(mk(0, 12'h008, pa,  0,   0,   1,  3, 2,  2, 0));
    tbl.push_back(mk(0, 12'h008, pa,  1,   0,   0,  3, 2,  2, 1));
    tbl.push_back(mk(0, 12'h000, pa,  0,   1,   0,  0, 0,  0, 0));
    tbl.push_back(mk(1, 12'h000, '0,  0,   0,   0,  0, 0,  0, 0)); // fresh pointer
    tbl.push_back(mk(0, 12'h212, pb,  0,   0,   1,  1, 6,  6, 0)); // rr 1,4,9,1
    tbl.push_back(mk(0, 12'h212, pb,  1,   0,   0,  1, 6,  6, 1));
    tbl.push_back(mk(0, 12'h212, pb,  0,   1,   0,  0, 0,  6, 0)); // dead cycle
    tbl.push_back(mk(0, 12'h212, pb,  0,   0,   1,  4, 6,  6, 0));
    tbl.push_back(mk(0, 12'h212, pb,  1,   0,   0,  4, 6,  6, 1));
    tbl.push_back(mk(0, 12'h212, pb,  0,   1,   0,  0, 0,  6, 0));
    tbl.push_back(mk(0, 12'h212, pb,  0,   0,   1,  9, 6,  6, 0));
    tbl.push_back(mk(0, 12'h212, pb,  1,   0,   0,  9, 6,  6, 1));
    tbl.push_back(mk(0, 12'h212, pb,  0,   1,   0,  0, 0,  6, 0));
    tbl.push_back(mk(0, 12'h212, pb,  0,   0,   1,  1, 6,  6, 0));
    tbl.push_back(mk(0, 12'h212, pb,  1,   0,   0,  1, 6,  6, 1));
    tbl.push_back(mk(0, 12'h210, pb,  0,   1,   0,  0, 0,  6, 0));
    tbl.push_back(mk(0, 12'h210, pb,  0,   0,   1,  4, 6,  6, 0)); // grant ch4
    tbl.push_back(mk(0, 12'h200, pb,  0,   0,   0,  0, 0,  6, 0)); // withdraw ch4
    tbl.push_back(mk(0, 12'h210, pb,  0,   0,   1,  4, 6,  6, 0)); // pointer unchanged
    tbl.push_back(mk(0, 12'h210, pb,  0,   1,   1,  4, 6,  6, 0)); // done in GRANT ignored
    tbl.push_back(mk(0, 12'h200, pb,  1,   0,   0,  4, 6,  6, 1)); // ack beats withdrawal
    tbl.push_back(mk(0, 12'h000, pb,  0,   1,   0,  0, 0,  0, 0));
    tbl.push_back(mk(0, 12'h000, pb,  1,   0,   0,  0, 0,  0, 0)); // ack in IDLE ignored

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = !tbl[i].rst; valid = tbl[i].v; pri_ch = tbl[i].p;
      gnt_ack = tbl[i].ack; ch_done = tbl[i].done;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d gnt_valid", i), 32'(gv_a), 32'(tbl[i].egv));
      chk($sformatf("row%0d busy", i), 32'(busy_a), 32'(tbl[i].ebusy));
      chk($sformatf("row%0d pri_out", i), 32'(po_a), 32'(tbl[i].epo));
      if (tbl[i].egv || tbl[i].ebusy || tbl[i].rst) begin
        chk($sformatf("row%0d gnt_ch", i), 32'(ch_a), 32'(tbl[i].ech));
        chk($sformatf("row%0d gnt_pri", i), 32'(gp_a), 32'(tbl[i].epri));
      end
    end

    // Two-level priority masking: ch2 pri 5 -> 1, ch5 pri 6 -> 0.
    do_reset();
    @(negedge clk);
    valid = 12'h024; pri_ch = pv(2, 5, 5, 6); gnt_ack = 0; ch_done = 0;
    @(posedge clk); #1;
    chk("lv2 gnt_valid", 32'(gv_b), 32'd1);
    chk("lv2 gnt_ch", 32'(ch_b), 32'd2);
    chk("lv2 gnt_pri", 32'(gp_b), 32'd1);
    chk("lv2 pri_out", 32'(po_b), 32'd1);
    chk("lv8 gnt_ch", 32'(ch_a), 32'd5);
    chk("lv8 pri_out", 32'(po_a), 32'd6);

    // Asynchronous reset while BUSY, then a tie must go to ch0.
    do_reset();
    @(negedge clk);
    valid = 12'h008; pri_ch = pv(3, 3);
    @(posedge clk); #1;
    chk("rb grant ch3", 32'(ch_a), 32'd3);
    @(negedge clk);
    gnt_ack = 1;
    @(posedge clk); #1;
    chk("rb busy", 32'(busy_a), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rb async busy", 32'(busy_a), 32'd0);
    chk("rb async gnt_valid", 32'(gv_a), 32'd0);
    chk("rb async pri_out", 32'(po_a), 32'd0);
    @(negedge clk);
    gnt_ack = 0; valid = 12'h021; pri_ch = pv(0, 3, 5, 3);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rb tie gnt_valid", 32'(gv_a), 32'd1);
    chk("rb tie gnt_ch", 32'(ch_a), 32'd0);

    // Randomized run against the model, both priority widths.
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) valid = 12'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) pri_ch = {4'($urandom), $urandom};
      gnt_ack = 1'($urandom_range(0, 1));
      ch_done = ($urandom_range(0, 2) == 0);
      m_step();
      @(posedge clk); #1;
      chk("rnd a gnt_valid", 32'(gv_a), 32'(m_gv[0]));
      chk("rnd a busy", 32'(busy_a), 32'(m_busy[0]));
      chk("rnd a pri_out", 32'(po_a), 32'(m_po[0]));
      chk("rnd b gnt_valid", 32'(gv_b), 32'(m_gv[1]));
      chk("rnd b busy", 32'(busy_b), 32'(m_busy[1]));
      chk("rnd b pri_out", 32'(po_b), 32'(m_po[1]));
      if (m_gv[0] != 0 || m_busy[0] != 0) begin
        chk("rnd a gnt_ch", 32'(ch_a), 32'(m_ch[0]));
        chk("rnd a gnt_pri", 32'(gp_a), 32'(m_pri[0]));
      end
      if (m_gv[1] != 0 || m_busy[1] != 0) begin
        chk("rnd b gnt_ch", 32'(ch_b), 32'(m_ch[1]));
        chk("rnd b gnt_pri", 32'(gp_b), 32'(m_pri[1]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_dma_ch_arb.md
# ahb_dma_ch_arb

Parametrised channel arbiter for the AHB DMA: selects one requesting channel per transfer by programmed priority, with round-robin among equal-priority channels. It keeps the registered "highest pending priority" output of the current priority encoder and adds an explicit grant/ack/done handshake toward the DMA transfer engine. It sits between the per-channel register/request logic and the AHB master state machine.

## Interface
- CH_NUM, 12, number of channels; legal range 2..32
- PRI_LEVELS, 8, number of priority levels; legal values 2, 4, 8
- CH_W, $clog2(CH_NUM), channel index width (derived, not overridden)
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- valid  input  CH_NUM  per-channel request; bit k = channel k
- pri_ch  input  3 x [0:CH_NUM-1]  per-channel priority; only the low $clog2(PRI_LEVELS) bits are used, upper bits ignored
- gnt_ack  input  1  engine accepts the current grant
- ch_done  input  1  engine finished the granted channel's transfer
- pri_out  output  3  registered maximum effective priority among valid channels
- gnt_valid  output  1  a grant is offered
- gnt_ch  output  CH_W  granted channel index
- gnt_pri  output  3  effective priority of the granted channel
- busy  output  1  a granted transfer is in progress

## Operation
- Effective priority = pri_ch[k] masked to log2(PRI_LEVELS) bits; a higher value wins.
- pri_out: registered every cycle, independent of FSM, as the maximum effective priority over channels with valid=1; 0 if none.
- Winner: among valid channels with the maximum effective priority, pick the first index strictly after last_ch in ascending, wrapping order (last_ch itself is considered last).
- last_ch register: reset value CH_NUM-1, so channel 0 wins the first tie. Updated to gnt_ch only on an accepted grant.
- FSM states: IDLE, GRANT, BUSY.
  - IDLE: if any valid, register winner into gnt_ch/gnt_pri, go to GRANT; otherwise stay.
  - GRANT: gnt_valid=1; gnt_ch/gnt_pri held stable. If gnt_ack, update last_ch and go to BUSY. If gnt_ack=0 and valid[gnt_ch]=0 (request withdrawn), go to IDLE with no pointer update. gnt_ack takes precedence over withdrawal in the same cycle.
  - BUSY: busy=1; gnt_ch held. On ch_done, go to IDLE. Requests arriving meanwhile are not granted.
- ch_done outside BUSY and gnt_ack outside GRANT are ignored.
- No preemption: a higher-priority request during GRANT or BUSY waits.

## Timing
- Reset (asynchronous, rst_n=0) clears pri_out=0, gnt_valid=0, gnt_ch=0, gnt_pri=0, busy=0, state IDLE, and sets last_ch=CH_NUM-1. Reset mid-transfer aborts it with no residual state.
- Grant latency: valid sampled in IDLE at edge N makes gnt_valid=1 after edge N, so gnt_valid is visible in cycle N+1.
- pri_out latency: 1 cycle after valid/pri_ch change.
- Ack at edge M: busy=1 and gnt_valid=0 after edge M.
- ch_done at edge P: IDLE after edge P. The next grant becomes visible no earlier than after edge P+1, giving one dead cycle between transfers.
- Withdrawal in GRANT: gnt_valid drops after the same edge.

## Structure
- Shared package ahb_dma_pkg holds:
  - the arb_state_t enum (IDLE, GRANT, BUSY)
  - the constant PRI_W = 3
- One sub-module, ahb_dma_rr_pick:
  - combinational rotate/find-first over an eligibility mask, with the start pointer as an input
  - outputs winner index and found flag
- Max-priority reduction and masking stay inline.

## Test plan
- Reset with valid=all ones -> all outputs 0 during reset; the first grant after release is ch0, visible 1 cycle after reset deassert.
- CH_NUM=12, PRI_LEVELS=8, valid[3]=valid[7]=1, pri 2 and 5 -> gnt_ch=7, gnt_pri=5, pri_out=5; ack, done -> next grant ch3.
- Channels 1, 4, 9 all pri 6 and held valid, with ack and done each round -> grant order 1, 4, 9, 1.
- PRI_LEVELS=2, ch2 pri=5 (effective 1) and ch5 pri=6 (effective 0) -> gnt_ch=2, pri_out=1.
- In GRANT on ch4, drop valid[4] with no ack -> gnt_valid=0 next cycle; the subsequent tie winner is unchanged (last_ch not updated).
- rst_n asserted while in BUSY -> busy=0 immediately; the first tie after release is won by ch0.
